// File: rtl/cache_mem_ctrl_if.sv
// Cache <-> memory-controller <-> RAM signal bundle.
// The slave modport is the controller's view; the master modport is the caches/RAM side.
interface cache_mem_ctrl_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [31:0] ifill_cnt;
    logic [31:0] dread_cnt;
    logic [31:0] dwrite_cnt;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               ifill_cnt, dread_cnt, dwrite_cnt
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               ifill_cnt, dread_cnt, dwrite_cnt
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Arbitrates icache fills and dcache reads/writes onto a single-word RAM port.
// Optional completed-transaction counters are built when MC_STATS_EN is defined.
module cache_mem_ctrl (
    input  logic            CLK,
    input  logic            nRST,
    cache_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {MC_IDLE, MC_IFETCH, MC_DREAD, MC_DWRITE} mc_state_e;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    mc_state_e state_q;
    logic      last_d_q;
    logic      ren_q;
    logic      wen_q;
    logic      ram_ok;
    logic      i_done;
    logic      d_done;

    assign ram_ok = (bus.ramstate == RAM_ACCESS);
    // Completion needs the class's request still up; a dropped request is a withdrawal.
    assign i_done = (state_q == MC_IFETCH) && bus.iREN && ram_ok;
    assign d_done = ((state_q == MC_DREAD && bus.dREN) ||
                     (state_q == MC_DWRITE && bus.dWEN)) && ram_ok;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= MC_IDLE;
            last_d_q <= 1'b1;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    // Data goes first unless icache also waits and data was served last.
                    if ((bus.dREN || bus.dWEN) && (!bus.iREN || !last_d_q)) begin
                        if (bus.dWEN) begin
                            state_q <= MC_DWRITE;
                            wen_q   <= 1'b1;
                        end else begin
                            state_q <= MC_DREAD;
                            ren_q   <= 1'b1;
                        end
                    end else if (bus.iREN) begin
                        state_q <= MC_IFETCH;
                        ren_q   <= 1'b1;
                    end
                end
                MC_IFETCH: begin
                    if (!bus.iREN || ram_ok) begin
                        state_q <= MC_IDLE;
                        ren_q   <= 1'b0;
                        if (bus.iREN) last_d_q <= 1'b0;
                    end
                end
                MC_DREAD: begin
                    if (!bus.dREN || ram_ok) begin
                        state_q <= MC_IDLE;
                        ren_q   <= 1'b0;
                        if (bus.dREN) last_d_q <= 1'b1;
                    end
                end
                MC_DWRITE: begin
                    if (!bus.dWEN || ram_ok) begin
                        state_q <= MC_IDLE;
                        wen_q   <= 1'b0;
                        if (bus.dWEN) last_d_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MC_IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = (state_q == MC_IFETCH) ? bus.iaddr :
                          (state_q == MC_IDLE)   ? 32'd0     : bus.daddr;
    assign bus.ramstore = (state_q == MC_DWRITE) ? bus.dstore : 32'd0;
    assign bus.iwait    = !i_done;
    assign bus.dwait    = !d_done;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;

`ifdef MC_STATS_EN
    logic [31:0] ifill_cnt_q;
    logic [31:0] dread_cnt_q;
    logic [31:0] dwrite_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifill_cnt_q  <= 32'd0;
            dread_cnt_q  <= 32'd0;
            dwrite_cnt_q <= 32'd0;
        end else begin
            if (i_done)                             ifill_cnt_q  <= ifill_cnt_q + 32'd1;
            if (d_done && state_q == MC_DREAD)      dread_cnt_q  <= dread_cnt_q + 32'd1;
            if (d_done && state_q == MC_DWRITE)     dwrite_cnt_q <= dwrite_cnt_q + 32'd1;
        end
    end

    assign bus.ifill_cnt  = ifill_cnt_q;
    assign bus.dread_cnt  = dread_cnt_q;
    assign bus.dwrite_cnt = dwrite_cnt_q;
`else
    assign bus.ifill_cnt  = 32'd0;
    assign bus.dread_cnt  = 32'd0;
    assign bus.dwrite_cnt = 32'd0;
`endif
endmodule
